// File: rtl/mp_addsub_seq_pkg.sv
// Shared types and constants for the slice-serial multi-precision adder/subtractor.
package mp_addsub_seq_pkg;

  localparam int unsigned DEFAULT_N     = 8;
  localparam int unsigned DEFAULT_WORDS = 4;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_slice.sv
// N-bit combinational add/subtract slice; cout is carry-out (add) or borrow-out (sub).
module addsub_slice
  import mp_addsub_seq_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         mode,
  output logic [N-1:0] r,
  output logic         cout
);

  logic [N:0] ext;

  // One extra bit: for subtraction it becomes the sign of the true slice difference.
  always_comb begin
    ext = '0;
    if (mode == MODE_ADD) begin
      ext = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    end else begin
      ext = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, cin};
    end
  end

  assign r    = ext[N-1:0];
  assign cout = ext[N];

endmodule

// File: rtl/mp_addsub_seq.sv
// Slice-serial W-bit adder/subtractor processing one N-bit slice per cycle, LSB first.
// Optional signed overflow output enabled by defining OVF_DETECT_EN.
module mp_addsub_seq
  import mp_addsub_seq_pkg::*;
#(
  parameter int unsigned N     = DEFAULT_N,
  parameter int unsigned WORDS = DEFAULT_WORDS,
  localparam int unsigned W    = N * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         cin,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout
`ifdef OVF_DETECT_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned IdxW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            mode_q, mode_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
`ifdef OVF_DETECT_EN
  logic            ovf_q, ovf_d;
`endif

  logic [N-1:0] slice_a, slice_b, slice_r;
  logic         slice_cout;

  assign slice_a = a_q[idx_q*N +: N];
  assign slice_b = b_q[idx_q*N +: N];

  addsub_slice #(
    .N(N)
  ) u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .mode(mode_q),
    .r   (slice_r),
    .cout(slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
`ifdef OVF_DETECT_EN
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = a;
          b_d     = b;
          mode_d  = mode;
          carry_d = cin;
          idx_d   = '0;
        end
      end
      StRun: begin
        result_d[idx_q*N +: N] = slice_r;
        carry_d                = slice_cout;
        idx_d                  = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
`ifdef OVF_DETECT_EN
          // Carry (or borrow) into the top bit is a ^ b ^ r at that bit, for add and sub alike.
          ovf_d   = slice_a[N-1] ^ slice_b[N-1] ^ slice_r[N-1] ^ slice_cout;
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      mode_q   <= MODE_ADD;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
`ifdef OVF_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
`ifdef OVF_DETECT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready  = (state_q == StIdle);
  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign result = result_q;
  // After the last slice the carry register holds the final carry/borrow until the next start.
  assign cout   = carry_q;
`ifdef OVF_DETECT_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Self-checking bench for mp_addsub_seq: directed corner cases plus randomized operations
// checked against a (W+1)-bit arithmetic reference model. Honours OVF_DETECT_EN.
module tb_mp_addsub_seq;

  localparam int unsigned N     = 8;
  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = N * WORDS;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic         cin;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf_obs;
`ifdef OVF_DETECT_EN
  logic         ovf;
  assign ovf_obs = ovf;
`else
  assign ovf_obs = 1'b0;
`endif

  int n_tests;
  int n_fail;

  mp_addsub_seq #(
    .N    (N),
    .WORDS(WORDS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout)
`ifdef OVF_DETECT_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < int'(W); i += 32) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  // Reference: whole-operand arithmetic, signed overflow from true signed range.
  function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                input logic mm, input logic mc,
                                output logic [W-1:0] r, output logic co, output logic ov);
    logic [W:0] full;
    longint sa, sb, s, smax, smin;
    if (!mm) full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
    else     full = {1'b0, ma} - {1'b0, mb} - (W+1)'(mc);
    r  = full[W-1:0];
    co = full[W];
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    s  = mm ? (sa - sb - longint'(mc)) : (sa + sb + longint'(mc));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    ov = (s > smax) || (s < smin);
  endfunction

  // Caller is at a negedge; waits for ready, issues one op, returns at the negedge of done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tm,
                       input logic tc, input bit scramble,
                       output logic [W-1:0] r, output logic co, output logic ov,
                       output int lat, output int idle_wait);
    idle_wait = 0;
    while (!ready && idle_wait < 20) begin
      @(negedge clk);
      idle_wait++;
    end
    a = ta; b = tb_v; mode = tm; cin = tc; start = 1'b1;
    lat = 0; r = '0; co = 1'b0; ov = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      start = 1'b0;
      if (scramble) begin
        a = rand_w(); b = rand_w(); mode = 1'($urandom); cin = 1'($urandom);
      end
    end while (!done && lat < int'(4 * WORDS + 10));
    if (done) begin
      r = result; co = cout; ov = ovf_obs;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ready, busy, done, cout, ovf_obs} !== 5'b10000 || result !== '0) begin
      $display("FAIL reset_outputs: ready=%b busy=%b done=%b cout=%b ovf=%b result=%h, want 1 0 0 0 0 0",
               ready, busy, done, cout, ovf_obs, result);
      n_fail++;
    end
    rst = 1'b0;
  endtask

  task automatic test_directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                               input logic tm, input logic tc);
    logic [W-1:0] r, er;
    logic co, ov, eco, eov;
    int lat, iw;
    model(ta, tb_v, tm, tc, er, eco, eov);
    do_op(ta, tb_v, tm, tc, 1'b1, r, co, ov, lat, iw);
    n_tests++;
    if (r !== er || co !== eco) begin
      $display("FAIL %s: result=%h cout=%b, want %h %b", name, r, co, er, eco);
      n_fail++;
    end
    n_tests++;
    if (lat != int'(WORDS + 1)) begin
      $display("FAIL %s_latency: %0d cycles, want %0d", name, lat, WORDS + 1);
      n_fail++;
    end
`ifdef OVF_DETECT_EN
    n_tests++;
    if (ov !== eov) begin
      $display("FAIL %s_ovf: ovf=%b, want %b", name, ov, eov);
      n_fail++;
    end
`endif
  endtask

  task automatic test_ignored_start();
    logic [W-1:0] a1, b1, er, res;
    logic eco, eov, co;
    int ndone;
    bit seen, ready_bad;
    a1 = 32'h1357_9BDF; b1 = 32'h0246_8ACE;
    model(a1, b1, 1'b0, 1'b1, er, eco, eov);
    while (!ready) @(negedge clk);
    a = a1; b = b1; mode = 1'b0; cin = 1'b1; start = 1'b1;
    ndone = 0; seen = 1'b0; ready_bad = 1'b0; res = '0; co = 1'b0;
    for (int k = 1; k <= int'(WORDS + 4); k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        start = 1'b1; a = 32'hFFFF_0000; b = 32'h0000_FFFF; mode = 1'b1;
      end
      if (done) begin
        ndone++; res = result; co = cout; seen = 1'b1; start = 1'b0;
      end else if (!seen && ready) begin
        ready_bad = 1'b1;
      end
    end
    n_tests++;
    if (ndone != 1) begin
      $display("FAIL ignored_start_pulses: %0d done pulses, want 1", ndone);
      n_fail++;
    end
    n_tests++;
    if (res !== er || co !== eco) begin
      $display("FAIL ignored_start_result: result=%h cout=%b, want %h %b", res, co, er, eco);
      n_fail++;
    end
    n_tests++;
    if (ready_bad) begin
      $display("FAIL ignored_start_ready: ready=1 before done, want 0");
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] r;
    logic co, ov;
    int lat, iw, ndone;
    while (!ready) @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; mode = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({ready, busy, done, cout, ovf_obs} !== 5'b10000 || result !== '0) begin
      $display("FAIL reset_mid_op: ready=%b busy=%b done=%b cout=%b ovf=%b result=%h, want 1 0 0 0 0 0",
               ready, busy, done, cout, ovf_obs, result);
      n_fail++;
    end
    rst = 1'b0;
    ndone = 0;
    repeat (WORDS + 3) begin
      @(negedge clk);
      if (done) ndone++;
    end
    n_tests++;
    if (ndone != 0) begin
      $display("FAIL reset_no_done: %0d done pulses, want 0", ndone);
      n_fail++;
    end
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, r, co, ov, lat, iw);
    n_tests++;
    if (r !== 32'h2345_6789 || co !== 1'b0) begin
      $display("FAIL reset_then_add: result=%h cout=%b, want 23456789 0", r, co);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, er;
    logic co, ov, eco, eov;
    int lat, iw;
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] ta, tb_v;
      logic tm, tc;
      ta = rand_w(); tb_v = rand_w(); tm = 1'($urandom); tc = 1'($urandom);
      model(ta, tb_v, tm, tc, er, eco, eov);
      do_op(ta, tb_v, tm, tc, 1'b0, r, co, ov, lat, iw);
      n_tests++;
      if (r !== er || co !== eco || lat != int'(WORDS + 1) || (i > 0 && iw != 1)) begin
        $display("FAIL back_to_back[%0d]: result=%h cout=%b lat=%0d idle_wait=%0d, want %h %b %0d 1",
                 i, r, co, lat, iw, er, eco, WORDS + 1);
        n_fail++;
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] r, er, ta, tb_v;
    logic co, ov, eco, eov, tm, tc;
    int lat, iw, bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      ta = rand_w(); tb_v = rand_w(); tm = 1'($urandom); tc = 1'($urandom);
      case ($urandom_range(0, 7))
        0: ta = '1;
        1: tb_v = '1;
        2: ta = '0;
        default: ;
      endcase
      model(ta, tb_v, tm, tc, er, eco, eov);
      do_op(ta, tb_v, tm, tc, 1'b1, r, co, ov, lat, iw);
`ifndef OVF_DETECT_EN
      eov = 1'b0;
`endif
      n_tests++;
      if (r !== er || co !== eco || ov !== eov || lat != int'(WORDS + 1)) begin
        if (bad < 10)
          $display("FAIL random[%0d]: a=%h b=%h m=%b c=%b got r=%h co=%b ov=%b lat=%0d, want %h %b %b %0d",
                   i, ta, tb_v, tm, tc, r, co, ov, lat, er, eco, eov, WORDS + 1);
        bad++;
        n_fail++;
      end
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    test_directed("sub_borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0);
    test_directed("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    test_directed("sub_ovf_borrowin", 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    test_directed("add_carry_chain", 32'h00FF_FF00, 32'h0000_0100, 1'b0, 1'b1);
    test_ignored_start();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mp_addsub_seq.md
MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

Interface
REQ-001 Parameter N, default 8: slice width in bits.
REQ-002 Parameter WORDS, default 4: slices per operand; operand width W = N*WORDS; legal range 1..16.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request a new operation; sampled only when ready=1.
REQ-007 mode  input  1  0 = add, 1 = subtract; latched on accepted start.
REQ-008 cin  input  1  carry-in (add) or borrow-in (sub); latched on accepted start.
REQ-009 a  input  W  operand A; latched on accepted start.
REQ-010 b  input  W  operand B; latched on accepted start.
REQ-011 ready  output  1  high only in IDLE.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse, high in DONE.
REQ-014 result  output  W  sum or difference; valid from done until the next accepted start.
REQ-015 cout  output  1  final carry (add) or final borrow (sub); valid with result.
REQ-016 ovf  output  1  signed overflow; present only under OVF_DETECT_EN.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE to RUN on start=1: latch a, b, mode and cin; slice index idx=0; carry register = cin.
REQ-019 RUN processes exactly one N-bit slice per cycle, least-significant slice first.
REQ-020 Add slice: {c', r_idx} = a_idx + b_idx + c.
REQ-021 Sub slice: r_idx = a_idx - b_idx - c; c' = 1 when the true slice difference is negative.
REQ-022 Each RUN cycle: write r_idx into result[idx*N +: N]; carry = c'; idx = idx+1.
REQ-023 RUN to DONE after the cycle that processes idx = WORDS-1.
REQ-024 DONE to IDLE unconditionally after one cycle.
REQ-025 Latency: start accepted at edge t, done high in cycle t+WORDS+1; throughput is one operation per WORDS+2 cycles.
REQ-026 start is ignored while busy or done is high; operands change freely during RUN without effect.
REQ-027 cout = carry register after the last slice; it is held together with result.
REQ-028 start=1 in the IDLE cycle immediately following DONE is accepted normally.
REQ-029 Wrap-around is modulo 2^W; an all-ones plus one result yields 0 with cout=1.

Reset
REQ-030 rst=1 at any clock edge, including mid-RUN: state=IDLE, idx=0, carry=0, result=0, cout=0, done=0, busy=0, ready=1, ovf=0.
REQ-031 A partial operation aborted by reset produces no done pulse.
REQ-032 Reset has priority over start in the same cycle.

Configuration
REQ-033 Macro OVF_DETECT_EN defined: port ovf is present.
REQ-034 ovf = carry into the MSB of the top slice XOR carry out of the top slice (two's-complement overflow for add or sub); valid with result.
REQ-035 OVF_DETECT_EN undefined: port ovf and its logic are absent; all other behaviour is identical.

Structure
REQ-036 Shared package holds: the state enum (IDLE, RUN, DONE), the mode encoding constants MODE_ADD=0 and MODE_SUB=1, and the default N/WORDS constants.
REQ-037 One sub-module addsub_slice (N-bit combinational add/sub with a, b, cin, mode in; r, cout out) is instantiated once and shared across all cycles; the controller holds all sequential state.

Verification
REQ-038 Add wrap: a=0xFFFFFFFF, b=0x00000001, cin=0, mode=0 -> result=0x00000000, cout=1, done exactly 5 cycles after start.
REQ-039 Sub borrow: a=0x00000000, b=0x00000001, cin=0, mode=1 -> result=0xFFFFFFFF, cout=1; with OVF_DETECT_EN, ovf=0.
REQ-040 Signed overflow (OVF_DETECT_EN): a=0x7FFFFFFF, b=0x00000001, add -> result=0x80000000, cout=0, ovf=1.
REQ-041 Ignored start: a second start with new operands during RUN -> first result unchanged; a single done pulse; ready stays low until IDLE.
REQ-042 Reset mid-op: rst pulsed in the second RUN cycle -> all outputs at reset values next cycle; no done; a following start with a=0x12345678, b=0x11111111, add -> result=0x23456789.
REQ-043 Random: 200 operations with random a, b, mode and cin compared against a W+1-bit reference model -> zero mismatches.
